cnf_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively enumerates all 2^N input assignments of a combinational CNF evaluator module and reads back its single output.
- Counts satisfying assignments (model count) and captures the first satisfying model.
- Optionally stops at the first model (SAT check mode).
- Sits between the dependency/Skolem flow's control logic and a generated formula module; bit i of the assignment bus drives formula variable v_(i+1).

---
 rtl/cnf_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_cnf_sweep_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cnf_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// cnf_sweep_ctrl
//
// Purpose:
//   Exhaustively walks all 2^N assignments of a combinational (or pipelined)
//   CNF evaluator, samples its single output for each assignment, counts the
//   satisfying assignments and captures the lowest-valued model. Can stop at
//   the first model (SAT-check mode) or be aborted mid-sweep.
//   Bit i of assign_out drives formula variable v_(i+1).
//
// Parameters:
//   N         number of formula variables (1..16)
//   EVAL_LAT  cycles between a stable assignment and a valid sat_in (0..15)
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   start          begin a sweep (accepted only in IDLE)
//   stop_on_first  latched at start; end the sweep at the first model
//   abort          end the sweep early (honoured only in EVAL)
//   assign_out     candidate assignment presented to the evaluator
//   eval_valid     high while assign_out is being presented (EVAL)
//   sat_in         evaluator result for assign_out
//   busy           high in EVAL
//   done           one-cycle pulse when the sweep ends (FINISH)
//   found          at least one satisfying assignment seen this sweep
//   first_model    lowest-valued satisfying assignment (valid when found)
//   model_count    number of satisfying assignments (up to 2^N)
//   aborted        last sweep ended via abort
// ---------------------------------------------------------------------------
module cnf_sweep_ctrl #(
    parameter int N        = 5,
    parameter int EVAL_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop_on_first,
    input  logic         abort,
    output logic [N-1:0] assign_out,
    output logic         eval_valid,
    input  logic         sat_in,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [N-1:0] first_model,
    output logic [N:0]   model_count,
    output logic         aborted
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EVAL   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // Wait counter is wide enough for the largest supported latency (15).
    localparam logic [3:0] LAT = EVAL_LAT[3:0];

    logic [1:0]   r_state;
    logic [N-1:0] r_assign;
    logic [3:0]   r_wait;
    logic         r_stop;
    logic         r_found;
    logic [N-1:0] r_first;
    logic [N:0]   r_count;
    logic         r_aborted;

    logic w_sample;
    logic w_last;

    // The evaluator result is trusted only once the assignment has been
    // stable for EVAL_LAT cycles.
    assign w_sample = (r_state == S_EVAL) && (r_wait == LAT);
    assign w_last   = &r_assign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_assign  <= '0;
            r_wait    <= '0;
            r_stop    <= 1'b0;
            r_found   <= 1'b0;
            r_first   <= '0;
            r_count   <= '0;
            r_aborted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Results of the previous sweep stay visible until here.
                    if (start) begin
                        r_found   <= 1'b0;
                        r_first   <= '0;
                        r_count   <= '0;
                        r_aborted <= 1'b0;
                        r_stop    <= stop_on_first;
                        r_assign  <= '0;
                        r_wait    <= '0;
                        r_state   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (abort) begin
                        // Abort wins over a coincident sample: that sample
                        // is dropped and the counters stay as they are.
                        r_aborted <= 1'b1;
                        r_state   <= S_FINISH;
                    end else if (w_sample) begin
                        if (sat_in) begin
                            r_count <= r_count + 1'b1;
                            if (!r_found) begin
                                r_first <= r_assign;
                                r_found <= 1'b1;
                            end
                        end
                        if (r_stop && sat_in) begin
                            r_state <= S_FINISH;
                        end else if (w_last) begin
                            // No wrap: all-ones is the final assignment.
                            r_state <= S_FINISH;
                        end else begin
                            r_assign <= r_assign + 1'b1;
                            r_wait   <= '0;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign assign_out  = r_assign;
    assign eval_valid  = (r_state == S_EVAL);
    assign busy        = (r_state == S_EVAL);
    assign done        = (r_state == S_FINISH);
    assign found       = r_found;
    assign first_model = r_first;
    assign model_count = r_count;
    assign aborted     = r_aborted;

endmodule

// File: tb/tb_cnf_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cnf_sweep_ctrl
//
// Two instances of cnf_sweep_ctrl (N=5): index 0 with EVAL_LAT=0 driven by a
// combinational evaluator, index 1 with EVAL_LAT=2 driven by an evaluator
// whose result is computed from assign_out delayed two cycles.
// Each table row is one sweep; the expected result record is pushed to a
// scoreboard queue at start and popped/compared when done pulses.
// ---------------------------------------------------------------------------
module tb_cnf_sweep_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v     [2];
    logic       start_v   [2];
    logic       stop_v    [2];
    logic       abort_v   [2];
    logic [4:0] assign_v  [2];
    logic       valid_v   [2];
    logic       sat_v     [2];
    logic       busy_v    [2];
    logic       done_v    [2];
    logic       found_v   [2];
    logic [4:0] first_v   [2];
    logic [5:0] count_v   [2];
    logic       aborted_v [2];

    // 0: sat iff assignment is 19 or 27; 1: always sat; 2: never sat
    int mode = 0;

    function automatic logic eval_f(int m, logic [4:0] a);
        if (m == 1) return 1'b1;
        if (m == 2) return 1'b0;
        return (a == 5'd19) || (a == 5'd27);
    endfunction

    logic [4:0] d1, d2;
    always @(posedge clk) begin
        d1 <= assign_v[1];
        d2 <= d1;
    end

    always_comb begin
        sat_v[0] = eval_f(mode, assign_v[0]);
        sat_v[1] = eval_f(mode, d2);
    end

    cnf_sweep_ctrl #(.N(5), .EVAL_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
        .stop_on_first(stop_v[0]), .abort(abort_v[0]),
        .assign_out(assign_v[0]), .eval_valid(valid_v[0]), .sat_in(sat_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
        .first_model(first_v[0]), .model_count(count_v[0]),
        .aborted(aborted_v[0])
    );

    cnf_sweep_ctrl #(.N(5), .EVAL_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
        .stop_on_first(stop_v[1]), .abort(abort_v[1]),
        .assign_out(assign_v[1]), .eval_valid(valid_v[1]), .sat_in(sat_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
        .first_model(first_v[1]), .model_count(count_v[1]),
        .aborted(aborted_v[1])
    );

    typedef struct {
        int sel;       // which instance
        int m;         // evaluator mode
        int stop;      // stop_on_first
        int abort_at;  // assignment at which abort is raised (-1 = none)
        int mid;       // pulse start mid-sweep (must be ignored)
        int cyc;       // expected EVAL cycles
        int fnd;
        int first;
        int cnt;
        int ab;
        int asg;       // expected assign_out after done
    } vec_t;

    vec_t tbl [8];
    vec_t sb  [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_vec(int idx, vec_t v);
        int   s;
        int   cycles;
        bit   sent;
        bit   got_done;
        vec_t e;
        s        = v.sel;
        cycles   = 0;
        sent     = 1'b0;
        got_done = 1'b0;
        mode     = v.m;
        @(negedge clk);
        start_v[s] = 1'b1;
        stop_v[s]  = v.stop[0];
        sb.push_back(v);
        @(negedge clk);
        start_v[s] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done_v[s]) begin
                got_done = 1'b1;
                break;
            end
            if (busy_v[s]) cycles++;
            start_v[s] = (v.mid != 0) && (cycles == 5);
            if (v.abort_at >= 0 && !sent && busy_v[s] &&
                int'(assign_v[s]) == v.abort_at) begin
                abort_v[s] = 1'b1;
                sent       = 1'b1;
            end else begin
                abort_v[s] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[s] = 1'b0;
        abort_v[s] = 1'b0;
        chk("done_seen", int'(got_done), 1);
        e = sb.pop_front();
        chk("eval_cycles", cycles, e.cyc);
        chk("found", int'(found_v[s]), e.fnd);
        chk("first_model", int'(first_v[s]), e.first);
        chk("model_count", int'(count_v[s]), e.cnt);
        chk("aborted", int'(aborted_v[s]), e.ab);
        chk("assign_held", int'(assign_v[s]), e.asg);
        $display("run %0d: dut=%0d mode=%0d cycles=%0d count=%0d found=%0d first=%0d aborted=%0d",
                 idx, s, v.m, cycles, count_v[s], found_v[s], first_v[s], aborted_v[s]);
        @(negedge clk);
        chk("done_one_cycle", int'(done_v[s]), 0);
        chk("busy_after", int'(busy_v[s]), 0);
    endtask

    task automatic chk_reset_state(int s);
        chk("rst_assign", int'(assign_v[s]), 0);
        chk("rst_valid", int'(valid_v[s]), 0);
        chk("rst_busy", int'(busy_v[s]), 0);
        chk("rst_done", int'(done_v[s]), 0);
        chk("rst_found", int'(found_v[s]), 0);
        chk("rst_first", int'(first_v[s]), 0);
        chk("rst_count", int'(count_v[s]), 0);
        chk("rst_aborted", int'(aborted_v[s]), 0);
    endtask

    initial begin
        vec_t rv;
        int   wait_n;
        //           sel m stp ab  mid cyc fnd 1st cnt ab asg
        tbl[0] = '{0, 0, 0, -1, 0, 32, 1, 19, 2,  0, 31};
        tbl[1] = '{0, 0, 1, -1, 0, 20, 1, 19, 1,  0, 19};
        tbl[2] = '{1, 1, 0, -1, 0, 96, 1, 0,  32, 0, 31};
        tbl[3] = '{1, 0, 0, -1, 0, 96, 1, 19, 2,  0, 31};
        tbl[4] = '{0, 1, 0, 7,  0, 8,  1, 0,  7,  1, 7};
        tbl[5] = '{0, 2, 0, -1, 1, 32, 0, 0,  0,  0, 31};
        tbl[6] = '{1, 1, 0, 7,  0, 22, 1, 0,  7,  1, 7};
        tbl[7] = '{1, 1, 1, -1, 0, 3,  1, 0,  1,  0, 0};

        for (int i = 0; i < 2; i++) begin
            rst_v[i]   = 1'b1;
            start_v[i] = 1'b0;
            stop_v[i]  = 1'b0;
            abort_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_reset_state(0);
        chk_reset_state(1);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Results must be held in IDLE until the next start.
        repeat (3) @(negedge clk);
        chk("hold_count", int'(count_v[1]), 1);
        chk("hold_found", int'(found_v[1]), 1);

        // Reset mid-sweep at assignment 10, then a clean full sweep.
        mode = 1;
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_n = 0;
        while (assign_v[0] != 5'd10 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        chk("reach_assign10", int'(assign_v[0]), 10);
        rst_v[0] = 1'b1;
        @(negedge clk);
        chk_reset_state(0);
        rst_v[0] = 1'b0;
        rv = '{0, 1, 0, -1, 0, 32, 1, 0, 32, 0, 31};
        run_vec(8, rv);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
